mult_share_arbiter: RTL

//   Shares one Q5.10 signed multiplier (mult_2in) between N_REQ requesters, e.g. the

---
 rtl/mult_pkg.sv | 12 +
 rtl/mult_2in.sv | 21 ++
 rtl/rr_grant.sv | 44 ++++
 rtl/mult_share_arbiter.sv | 116 +++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared fixed-point definitions for the multiplier-sharing block.
// Q5.10 signed operands and results. The full product is 32 bits, so the
// Q5.10 result sits in bits [25:10] of that product.
package mult_pkg;
  localparam int Q_FRAC = 10;
  localparam int DATA_W = 16;
  localparam int PROD_W = 32;
  localparam logic [DATA_W-1:0] Q_ONE = 16'h0400;

  typedef logic signed [DATA_W-1:0] q_t;
  typedef logic signed [PROD_W-1:0] prod_t;
endpackage

// File: rtl/mult_2in.sv
// Combinational Q5.10 signed multiplier.
//   a, b : signed Q5.10 operands
//   p    : (a*b) >> Q_FRAC, truncated to DATA_W bits. This wraps on overflow
//          and does not saturate.
module mult_2in
  import mult_pkg::*;
(
  input  q_t a,
  input  q_t b,
  output q_t p
);
  prod_t a_ext;
  prod_t b_ext;
  prod_t prod;

  // Sign-extend explicitly so the multiply is a true 32-bit signed multiply.
  assign a_ext = {{(PROD_W-DATA_W){a[DATA_W-1]}}, a};
  assign b_ext = {{(PROD_W-DATA_W){b[DATA_W-1]}}, b};
  assign prod  = a_ext * b_ext;
  assign p     = DATA_W'(prod >>> Q_FRAC);
endmodule

// File: rtl/rr_grant.sv
// Combinational round-robin grant.
//   req_valid : request vector
//   rr_ptr    : index with highest priority this cycle
//   enable    : when low, no grant is issued
//   grant     : one-hot grant. The first valid index at or after rr_ptr wins,
//               and the search wraps.
//   idx       : encoded form of grant (0 when there is no grant)
module rr_grant #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]  rr_ptr,
  input  logic             enable,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx
);
  // cand[k] is the requester index that has priority rank k. It is rr_ptr+k mod N_REQ.
  logic [ID_W:0]   sum  [N_REQ];
  logic [ID_W-1:0] cand [N_REQ];
  logic            found;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      assign sum[gi]  = {1'b0, rr_ptr} + (ID_W+1)'(gi);
      assign cand[gi] = (sum[gi] >= (ID_W+1)'(N_REQ)) ? ID_W'(sum[gi] - (ID_W+1)'(N_REQ))
                                                      : sum[gi][ID_W-1:0];
    end
  endgenerate

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (enable && !found && req_valid[cand[k]]) begin
        found           = 1'b1;
        grant[cand[k]]  = 1'b1;
        idx             = cand[k];
      end
    end
  end
endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one Q5.10 multiplier between N_REQ requesters.
// Requesters are served round-robin. The operands are registered (S1), the product
// is registered (S2), and the product is returned with the requester id.
//   clk, rst_n : clock and asynchronous active-low reset
//   req_valid  : per-requester operand-ready flags
//   req_a/b    : packed Q5.10 operands. Requester i uses [16i+15:16i].
//   req_ready  : one-hot grant. Handshake i = req_valid[i] & req_ready[i].
//   res_valid  : result valid, held until res_ready is high
//   res_ready  : result consumer ready
//   res_data   : Q5.10 product (truncated, wraps on overflow)
//   res_id     : index of the requester that issued the product
//   mul_count  : accepted-request counter, wraps
module mult_share_arbiter
  import mult_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [DATA_W*N_REQ-1:0] req_a,
  input  logic [DATA_W*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [DATA_W-1:0]       res_data,
  output logic [ID_W-1:0]         res_id,
  output logic [CNT_W-1:0]        mul_count
);
  q_t req_a_arr [N_REQ];
  q_t req_b_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_a_arr[gi] = req_a[DATA_W*gi +: DATA_W];
      assign req_b_arr[gi] = req_b[DATA_W*gi +: DATA_W];
    end
  endgenerate

  logic [ID_W-1:0]  rr_ptr_reg, rr_ptr_next;
  logic             s1_valid_reg;
  q_t               s1_a_reg, s1_b_reg;
  logic [ID_W-1:0]  s1_id_reg;
  logic             res_valid_reg;
  q_t               res_data_reg;
  logic [ID_W-1:0]  res_id_reg;
  logic [CNT_W-1:0] mul_count_reg;

  logic             stall;
  logic             handshake;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  q_t               prod;

  // A result that is held and not yet taken freezes the whole pipe.
  assign stall = res_valid_reg & ~res_ready;

  // rst_n gates the grant so that req_ready stays low while reset is held.
  rr_grant #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr_grant (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_reg),
    .enable    (~stall & rst_n),
    .grant     (grant),
    .idx       (grant_idx)
  );

  assign req_ready = grant;
  assign handshake = |(req_valid & grant);

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (handshake) begin
      rr_ptr_next = (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  mult_2in u_mult (
    .a (s1_a_reg),
    .b (s1_b_reg),
    .p (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg    <= '0;
      s1_valid_reg  <= 1'b0;
      s1_a_reg      <= '0;
      s1_b_reg      <= '0;
      s1_id_reg     <= '0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_id_reg    <= '0;
      mul_count_reg <= '0;
    end else if (!stall) begin
      rr_ptr_reg   <= rr_ptr_next;
      s1_valid_reg <= handshake;
      if (handshake) begin
        s1_a_reg      <= req_a_arr[grant_idx];
        s1_b_reg      <= req_b_arr[grant_idx];
        s1_id_reg     <= grant_idx;
        mul_count_reg <= mul_count_reg + 1'b1;
      end
      res_valid_reg <= s1_valid_reg;
      res_data_reg  <= prod;
      res_id_reg    <= s1_id_reg;
    end
  end

  assign res_valid = res_valid_reg;
  assign res_data  = res_data_reg;
  assign res_id    = res_id_reg;
  assign mul_count = mul_count_reg;
endmodule
